// File: rtl/fcm_pkg.sv
// -----------------------------------------------------------------------------
// fcm_pkg
// Shared definitions for the flight-control rpm scanner:
//   - state_t    : scan FSM states
//   - DEF_*      : default rpm model coefficients and overspeed threshold
//   - acc_width  : width of the signed internal rpm accumulator for a given
//                  voltage sample width
// Optional feature macro used by the scanner: FCM_PEAK_HOLD_EN
// -----------------------------------------------------------------------------
package fcm_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SQ   = 3'd1,
      CUBE = 3'd2,
      EVAL = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int DEF_C_LIN      = 1400;
   localparam int DEF_C_CUB      = 173;
   localparam int DEF_CUB_SHIFT  = 6;
   localparam int DEF_RPM_THRESH = 10000;

   // Room for C_CUB*v^3 (3*V_W bits plus a 16-bit coefficient) with headroom
   // for the sign of the linear-minus-cubic difference.
   function automatic int acc_width(input int v_w);
      return 3 * v_w + 16;
   endfunction

endpackage

// File: rtl/fcm_rpm_eval.sv
// -----------------------------------------------------------------------------
// fcm_rpm_eval
// Registered rpm datapath for one voltage sample:
//   SQ   stage : r_v2 = v^2, r_lin = C_LIN*v
//   CUBE stage : r_cube = (C_CUB*v*v^2) >> CUB_SHIFT
//   EVAL       : o_rpm = clamp(r_lin - r_cube), combinational from the registers
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_sq_en      load the SQ stage registers
//   i_cube_en    load the CUBE stage register
//   i_v          voltage sample, held stable by the caller across SQ and CUBE
//   o_rpm        clamped/saturated rpm, valid while the caller is in EVAL
// -----------------------------------------------------------------------------
module fcm_rpm_eval
   import fcm_pkg::*;
#(
   parameter int V_W       = 8,
   parameter int RPM_W     = 16,
   parameter int C_LIN     = DEF_C_LIN,
   parameter int C_CUB     = DEF_C_CUB,
   parameter int CUB_SHIFT = DEF_CUB_SHIFT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_sq_en,
   input  logic             i_cube_en,
   input  logic [V_W-1:0]   i_v,
   output logic [RPM_W-1:0] o_rpm
);

   localparam int ACC_W = acc_width(V_W);

   logic [2*V_W-1:0]        r_v2;
   logic [ACC_W-1:0]        r_lin;
   logic [ACC_W-1:0]        r_cube;
   logic [ACC_W-1:0]        w_v_ext;
   logic [ACC_W-1:0]        w_lin;
   logic [ACC_W-1:0]        w_cube;
   logic signed [ACC_W-1:0] w_diff;

   // Negative results clamp to zero, anything above the rpm range saturates.
   function automatic logic [RPM_W-1:0] clamp_sat(input logic signed [ACC_W-1:0] d);
      if (d[ACC_W-1])
         return '0;
      else if (|d[ACC_W-2:RPM_W])
         return '1;
      else
         return d[RPM_W-1:0];
   endfunction

   assign w_v_ext = ACC_W'(i_v);
   assign w_lin   = w_v_ext * ACC_W'(C_LIN);
   assign w_cube  = (ACC_W'(C_CUB) * w_v_ext * ACC_W'(r_v2)) >> CUB_SHIFT;
   assign w_diff  = $signed(r_lin) - $signed(r_cube);
   assign o_rpm   = clamp_sat(w_diff);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v2   <= '0;
         r_lin  <= '0;
         r_cube <= '0;
      end else begin
         // SQ stage boundary
         if (i_sq_en) begin
            r_v2  <= (2*V_W)'(i_v) * (2*V_W)'(i_v);
            r_lin <= w_lin;
         end
         // CUBE stage boundary
         if (i_cube_en) begin
            r_cube <= w_cube;
         end
      end
   end

endmodule

// File: rtl/flight_ctrl_rpm_scanner.sv
// -----------------------------------------------------------------------------
// flight_ctrl_rpm_scanner
// Snapshots N_CH motor voltages on start and evaluates them one channel at a
// time on a shared rpm datapath (fcm_rpm_eval). Each channel's rpm is compared
// with RPM_THRESH and qualified by a debounce counter to produce overspeed
// flags; a selected channel is presented on the status outputs.
// Optional feature macro: FCM_PEAK_HOLD_EN (per-channel peak-rpm hold).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       scan request (ignored unless idle)
//   v           channel voltages, channel i at [i*V_W +: V_W]
//   sel         channel select for result / rpm_sel / peak_sel
//   busy        scan in progress
//   done        one-cycle pulse at the end of a scan
//   flags       debounced overspeed flag per channel
//   result      8'hFF when flags[sel] is set, else 8'h00 (registered)
//   rpm_sel     last rpm of channel sel (registered)
//   peak_clr    clears the peak registers (peak-hold builds only)
//   peak_sel    peak rpm of channel sel (0 without peak hold)
// -----------------------------------------------------------------------------
module flight_ctrl_rpm_scanner
   import fcm_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int V_W        = 8,
   parameter int RPM_W      = 16,
   parameter int C_LIN      = DEF_C_LIN,
   parameter int C_CUB      = DEF_C_CUB,
   parameter int CUB_SHIFT  = DEF_CUB_SHIFT,
   parameter int RPM_THRESH = DEF_RPM_THRESH,
   parameter int DEB_CNT    = 3,
   localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N_CH*V_W-1:0] v,
   input  logic [SEL_W-1:0]    sel,
   output logic                busy,
   output logic                done,
   output logic [N_CH-1:0]     flags,
   output logic [7:0]          result,
   output logic [RPM_W-1:0]    rpm_sel,
   input  logic                peak_clr,
   output logic [RPM_W-1:0]    peak_sel
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N_CH*V_W-1:0] r_snap;
   logic [SEL_W-1:0]    r_ch;
   logic [RPM_W-1:0]    r_rpm [N_CH];
   logic [7:0]          r_cnt [N_CH];
   logic [N_CH-1:0]     r_flags;
   logic [7:0]          r_result;
   logic [RPM_W-1:0]    r_rpm_sel;

   logic                w_capture;
   logic                w_sq_en;
   logic                w_cube_en;
   logic                w_eval;
   logic                w_last;
   logic                w_sel_ok;
   logic [V_W-1:0]      w_v_cur;
   logic [RPM_W-1:0]    w_rpm;
   logic [7:0]          w_cnt_cur;
   logic [7:0]          w_cnt_nxt;

   assign w_last   = (int'(r_ch) == N_CH - 1);
   assign w_sel_ok = (int'(sel) < N_CH);
   assign w_v_cur  = r_snap[r_ch*V_W +: V_W];

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_capture   = 1'b0;
      w_sq_en     = 1'b0;
      w_cube_en   = 1'b0;
      w_eval      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_capture   = 1'b1;
               w_state_nxt = SQ;
            end
         end
         SQ: begin
            busy        = 1'b1;
            w_sq_en     = 1'b1;
            w_state_nxt = CUBE;
         end
         CUBE: begin
            busy        = 1'b1;
            w_cube_en   = 1'b1;
            w_state_nxt = EVAL;
         end
         EVAL: begin
            busy        = 1'b1;
            w_eval      = 1'b1;
            w_state_nxt = w_last ? DONE : SQ;
         end
         DONE: begin
            // start is not sampled here, so a request in this cycle is dropped
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- snapshot / channel index ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_snap <= '0;
         r_ch   <= '0;
      end else if (w_capture) begin
         r_snap <= v;
         r_ch   <= '0;
      end else if (w_eval && !w_last) begin
         r_ch   <= r_ch + SEL_W'(1);
      end
   end

   fcm_rpm_eval #(
      .V_W       (V_W),
      .RPM_W     (RPM_W),
      .C_LIN     (C_LIN),
      .C_CUB     (C_CUB),
      .CUB_SHIFT (CUB_SHIFT)
   ) u_eval (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sq_en   (w_sq_en),
      .i_cube_en (w_cube_en),
      .i_v       (w_v_cur),
      .o_rpm     (w_rpm)
   );

   // ---------------- EVAL: rpm store and debounce ----------------
   always_comb begin
      w_cnt_cur = r_cnt[r_ch];
      w_cnt_nxt = '0;
      if (w_rpm > RPM_W'(RPM_THRESH)) begin
         w_cnt_nxt = (w_cnt_cur >= 8'(DEB_CNT)) ? 8'(DEB_CNT) : w_cnt_cur + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_rpm[i] <= '0;
            r_cnt[i] <= '0;
         end
         r_flags <= '0;
      end else if (w_eval) begin
         r_rpm[r_ch]   <= w_rpm;
         r_cnt[r_ch]   <= w_cnt_nxt;
         r_flags[r_ch] <= (w_cnt_nxt == 8'(DEB_CNT));
      end
   end

   // ---------------- output select ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result  <= '0;
         r_rpm_sel <= '0;
      end else if (w_sel_ok) begin
         r_result  <= r_flags[sel] ? 8'hFF : 8'h00;
         r_rpm_sel <= r_rpm[sel];
      end else begin
         r_result  <= '0;
         r_rpm_sel <= '0;
      end
   end

   assign flags   = r_flags;
   assign result  = r_result;
   assign rpm_sel = r_rpm_sel;

`ifdef FCM_PEAK_HOLD_EN
   logic [RPM_W-1:0] r_peak [N_CH];
   logic [RPM_W-1:0] r_peak_sel;

   // A clear coinciding with EVAL wins over the peak update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) r_peak[i] <= '0;
         r_peak_sel <= '0;
      end else begin
         if (peak_clr) begin
            for (int i = 0; i < N_CH; i++) r_peak[i] <= '0;
         end else if (w_eval && (w_rpm > r_peak[r_ch])) begin
            r_peak[r_ch] <= w_rpm;
         end
         r_peak_sel <= w_sel_ok ? r_peak[sel] : '0;
      end
   end

   assign peak_sel = r_peak_sel;
`else
   logic w_unused_peak_clr;
   assign w_unused_peak_clr = peak_clr;
   assign peak_sel          = '0;
`endif

endmodule

// File: tb/tb_flight_ctrl_rpm_scanner.sv
// -----------------------------------------------------------------------------
// tb_flight_ctrl_rpm_scanner
// Table-driven scans with a scoreboard: each scan pushes model rpm/flag
// expectations when start is driven, and they are popped and compared when
// done is observed. Hand sequences cover mid-scan reset and peak hold
// (FCM_PEAK_HOLD_EN).
// -----------------------------------------------------------------------------
module tb_flight_ctrl_rpm_scanner;

   localparam int N_CH = 4;
   localparam int LAT  = 3 * N_CH + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] v;
   logic [1:0]  sel;
   logic        busy;
   logic        done;
   logic [3:0]  flags;
   logic [7:0]  result;
   logic [15:0] rpm_sel;
   logic        peak_clr;
   logic [15:0] peak_sel;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   flight_ctrl_rpm_scanner #(.N_CH(N_CH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .v        (v),
      .sel      (sel),
      .busy     (busy),
      .done     (done),
      .flags    (flags),
      .result   (result),
      .rpm_sel  (rpm_sel),
      .peak_clr (peak_clr),
      .peak_sel (peak_sel)
   );

   typedef struct packed {
      logic [3:0][15:0] rpm;
      logic [3:0]       flags;
   } exp_t;

   typedef struct {
      logic [31:0] v;
      logic [31:0] v_mid;
      bit          mid_start;
      bit          done_start;
      logic [1:0]  sel;
      logic [3:0]  exp_flags;
      logic [7:0]  exp_result;
      logic [15:0] exp_rpm;
   } row_t;

   exp_t sb_q[$];
   int   m_cnt[4];
   row_t rows[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] m_rpm(input int unsigned vv);
      longint lin, cube, d;
      lin  = longint'(1400) * longint'(vv);
      cube = (longint'(173) * longint'(vv) * longint'(vv) * longint'(vv)) >>> 6;
      d    = lin - cube;
      if (d < 0) return 16'd0;
      if (d > 65535) return 16'hFFFF;
      return 16'(d);
   endfunction

   task automatic sb_push(input logic [31:0] vs);
      exp_t e;
      for (int c = 0; c < 4; c++) begin
         e.rpm[c] = m_rpm(32'(vs[c*8 +: 8]));
         if (e.rpm[c] > 16'd10000) m_cnt[c] = (m_cnt[c] >= 3) ? 3 : m_cnt[c] + 1;
         else                      m_cnt[c] = 0;
         e.flags[c] = (m_cnt[c] == 3);
      end
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      chk({tag, " sb_size"}, sb_q.size(), 1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      chk({tag, " flags"}, flags, e.flags);
      for (int c = 0; c < 4; c++) begin
         sel = 2'(c);
         tick();
         chk($sformatf("%s rpm_sel ch%0d", tag, c), rpm_sel, e.rpm[c]);
         chk($sformatf("%s result ch%0d", tag, c), result, e.flags[c] ? 8'hFF : 8'h00);
      end
   endtask

   // Drives start so the next edge samples it; returns #1 after that edge.
   task automatic start_scan(input logic [31:0] vs);
      v     = vs;
      start = 1'b1;
      tick();
      start = 1'b0;
      sb_push(vs);
      chk("busy after start", busy, 1);
   endtask

   // elapsed = edges already seen since the start edge. Latency counts edges
   // from the start edge to the first edge that samples done high.
   task automatic wait_done(input string tag, input int elapsed);
      int e;
      e = elapsed;
      while (done !== 1'b1 && e < 60) begin
         tick();
         e++;
      end
      chk({tag, " latency"}, e + 1, LAT);
   endtask

   task automatic scan_full(input string tag, input logic [31:0] vs);
      start_scan(vs);
      wait_done(tag, 0);
      tick();
      sb_check(tag);
   endtask

   task automatic run_row(input int idx, input row_t r);
      string tag;
      int    el;
      int    extra;
      tag = $sformatf("row%0d", idx);
      start_scan(r.v);
      tick();
      tick();
      v  = r.v_mid;
      el = 2;
      if (r.mid_start) begin
         tick();
         tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         el    = 5;
      end
      wait_done(tag, el);
      if (r.done_start) start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " done one cycle"}, done, 0);
      chk({tag, " busy after done"}, busy, 0);
      if (r.mid_start) begin
         extra = 0;
         for (int i = 0; i < 16; i++) begin
            tick();
            if (done) extra++;
         end
         chk({tag, " extra done"}, extra, 0);
      end
      sb_check(tag);
      sel = r.sel;
      tick();
      chk({tag, " tbl flags"}, flags, r.exp_flags);
      chk({tag, " tbl result"}, result, r.exp_result);
      chk({tag, " tbl rpm_sel"}, rpm_sel, r.exp_rpm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;

      //            v             v_mid         mid  dst  sel   flags    result  rpm
      rows[0] = '{32'h0064050D, 32'h0064050D, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00, 16'd12262};
      rows[1] = '{32'h0064050D, 32'hFFFFFFFF, 1'b0, 1'b0, 2'd0, 4'b0000, 8'h00, 16'd12262};
      rows[2] = '{32'h0064050D, 32'h0064050D, 1'b0, 1'b0, 2'd0, 4'b0001, 8'hFF, 16'd12262};
      rows[3] = '{32'h0064050D, 32'h00640505, 1'b0, 1'b0, 2'd1, 4'b0001, 8'h00, 16'd6663};
      rows[4] = '{32'h00640505, 32'h00640505, 1'b1, 1'b0, 2'd0, 4'b0000, 8'h00, 16'd6663};
      rows[5] = '{32'h140D0D00, 32'h140D0D00, 1'b0, 1'b1, 2'd2, 4'b0000, 8'h00, 16'd12262};
      rows[6] = '{32'h140D0D00, 32'h140D0D00, 1'b0, 1'b0, 2'd3, 4'b0000, 8'h00, 16'd6375};
      rows[7] = '{32'h140D0D00, 32'h140D0D00, 1'b0, 1'b0, 2'd1, 4'b0110, 8'hFF, 16'd12262};

      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      v        = '0;
      sel      = '0;
      peak_clr = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset flags", flags, 0);
      chk("reset result", result, 0);
      chk("reset rpm_sel", rpm_sel, 0);
      chk("reset peak_sel", peak_sel, 0);

      for (int i = 0; i < 8; i++) run_row(i, rows[i]);

      // Reset during CUBE of channel 2 aborts the scan without done.
      v     = 32'h0064050D;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) ndone++;
         tick();
      end
      chk("midreset done count", ndone, 0);
      chk("midreset busy", busy, 0);
      chk("midreset flags", flags, 0);
      chk("midreset result", result, 0);

`ifdef FCM_PEAK_HOLD_EN
      scan_full("peak13", 32'h0064050D);
      scan_full("peak5", 32'h00640505);
      sel = 2'd0;
      tick();
      tick();
      chk("peak hold ch0", peak_sel, 12262);
      peak_clr = 1'b1;
      tick();
      peak_clr = 1'b0;
      tick();
      chk("peak after clr", peak_sel, 0);
      start_scan(32'h0064050D);
      tick();
      tick();
      peak_clr = 1'b1;
      tick();
      peak_clr = 1'b0;
      wait_done("peakeval", 3);
      tick();
      sb_check("peakeval");
      sel = 2'd0;
      tick();
      tick();
      chk("peak clr at eval", peak_sel, 0);
`else
      scan_full("postreset", 32'h0064050D);
      sel = 2'd0;
      tick();
      chk("peak_sel tied", peak_sel, 0);
      chk("postreset rpm_sel", rpm_sel, 12262);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
